fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of decode and the `Branch` comparator. It owns the program counter and issues one outstanding request at a time to instruction memory over a valid/ready request plus valid response. It holds the returned word in a one-entry buffer until decode accepts it. It consumes the ID-stage redirect (`takeBranch`/`braTarget` from `Branch`, plus jumps) and discards wrong-path fetches, including a response still in flight.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_holdreg.sv | 31 +++
 rtl/fetch_unit.sv | 68 ++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC, fetch FSM states and PC alignment helper.
package fetch_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetchState_t;
  function automatic logic [INST_W-1:0] alignPc(input logic [INST_W-1:0] pc);
    return {pc[INST_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_holdreg.sv
// fetch_holdreg: one-entry instruction buffer between fetch and decode.
module fetch_holdreg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              drain,
  input  logic [INST_W-1:0] loadInst,
  input  logic [INST_W-1:0] loadPc,
  output logic              bufValid,
  output logic [INST_W-1:0] bufInst,
  output logic [INST_W-1:0] bufPc
);
  // a reload in the same cycle as a drain keeps the entry valid
  always_ff @(posedge clk) begin
    if (rst || clear) bufValid <= 1'b0;
    else if (load) bufValid <= 1'b1;
    else if (drain) bufValid <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bufInst <= '0;
      bufPc   <= '0;
    end else if (load) begin
      bufInst <= loadInst;
      bufPc   <= loadPc;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one outstanding imem request at a time, dropping wrong-path words.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              takeBranch,
  input  logic [INST_W-1:0] braTarget,
  input  logic              jumpEnable,
  input  logic [INST_W-1:0] jumpTarget,
  output logic              imemReq,
  output logic [INST_W-1:0] imemAddr,
  input  logic              imemReady,
  input  logic              imemValid,
  input  logic [INST_W-1:0] imemData,
  output logic              instValid,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] instPc
);
  fetchState_t       state;
  logic [INST_W-1:0] nextPc, reqPc, target;
  logic              redirect, drain, load, bufValid;

  assign redirect  = takeBranch | jumpEnable;
  assign target    = alignPc(jumpEnable ? jumpTarget : braTarget);
  assign instValid = bufValid & ~redirect;
  assign drain     = instValid & ~stall;
  assign imemReq   = ~rst & (state == IDLE) & (~bufValid | drain) & ~redirect;
  assign imemAddr  = nextPc;
  assign load      = (state == WAIT) & imemValid & ~redirect;

  // a redirect while a response is still in flight parks in DROP to swallow it
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      nextPc <= RESET_PC;
      reqPc  <= RESET_PC;
    end else begin
      if (redirect) nextPc <= target;
      else if (imemReq && imemReady) nextPc <= nextPc + 32'd4;
      case (state)
        IDLE: if (imemReq && imemReady) begin
          reqPc <= nextPc;
          state <= WAIT;
        end
        WAIT: state <= imemValid ? IDLE : (redirect ? DROP : WAIT);
        DROP: state <= imemValid ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_holdreg u_holdreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clear    (redirect),
    .drain    (drain),
    .loadInst (imemData),
    .loadPc   (reqPc),
    .bufValid (bufValid),
    .bufInst  (inst),
    .bufPc    (instPc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a latency-programmable memory model and request/instruction scoreboards.
module tb_fetch_unit;
  logic        clk, rst, stall, takeBranch, jumpEnable, imemReady, imemValid;
  logic [31:0] braTarget, jumpTarget, imemData;
  logic        imemReq, instValid;
  logic [31:0] imemAddr, inst, instPc;

  int          checks = 0, errors = 0;
  int          budget = 0, lat = 1, cnt = 0;
  logic        pend = 0;
  logic [31:0] pAddr;
  logic [15:0] hist;
  logic [31:0] reqQ[$];
  logic [31:0] instQ[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .takeBranch(takeBranch), .braTarget(braTarget),
    .jumpEnable(jumpEnable), .jumpTarget(jumpTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemValid(imemValid), .imemData(imemData),
    .instValid(instValid), .inst(inst), .instPc(instPc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: observe at negedge, then advance the memory model just after posedge
  task automatic tick();
    logic        acc;
    logic [31:0] accAddr, e;
    @(negedge clk);
    hist = {hist[14:0], instValid};
    acc = imemReq && imemReady;
    accAddr = imemAddr;
    if (acc) begin
      if (reqQ.size() > 0) e = reqQ.pop_front();
      else e = 32'hDEAD_BEEF;
      check("reqAddr", imemAddr, e);
    end
    if (instValid && !stall) begin
      if (instQ.size() > 0) e = instQ.pop_front();
      else e = 32'hFFFF_FFFF;
      check("instPc", instPc, e);
      check("inst", inst, memWord(e));
    end
    @(posedge clk);
    #1;
    imemValid = 0;
    if (acc) begin
      pend = 1;
      cnt = lat;
      pAddr = accAddr;
      budget--;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imemValid = 1;
        imemData = memWord(pAddr);
        pend = 0;
      end
    end
    imemReady = budget > 0;
  endtask

  task automatic grant(input int n);
    budget = n;
    imemReady = n > 0;
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while ((instQ.size() > 0 || pend) && n < bound) begin
      tick();
      n++;
    end
    check("drainTimeout", instQ.size(), 0);
  endtask

  initial begin
    rst = 1; stall = 0; takeBranch = 0; jumpEnable = 0; braTarget = 0; jumpTarget = 0;
    imemReady = 0; imemValid = 0; imemData = 0;
    tick();
    tick();
    #1;
    check("rstReq", imemReq, 0);
    check("rstValid", instValid, 0);
    check("rstAddr", imemAddr, 32'h3000);

    // sequential fetch with 1-cycle memory
    rst = 0;
    hist = 0;
    grant(3);
    reqQ.push_back(32'h3000); reqQ.push_back(32'h3004); reqQ.push_back(32'h3008);
    instQ.push_back(32'h3000); instQ.push_back(32'h3004); instQ.push_back(32'h3008);
    repeat (6) tick();
    check("validCadence", {26'd0, hist[5:0]}, 32'b001010);

    // stall with full buffer
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stallReq", imemReq, 0);
      check("stallValid", instValid, 1);
      check("stallPc", instPc, 32'h3008);
      check("stallInst", inst, memWord(32'h3008));
      tick();
    end
    stall = 0;
    grant(1);
    reqQ.push_back(32'h300C);
    instQ.push_back(32'h300C);
    waitDrain(20);

    // branch while response outstanding, response arrives 3 cycles after accept
    lat = 3;
    grant(1);
    reqQ.push_back(32'h3010);
    tick();
    takeBranch = 1; braTarget = 32'h3100;
    #1;
    check("branchNoReq", imemReq, 0);
    tick();
    takeBranch = 0;
    grant(1);
    #1;
    check("dropNoReq", imemReq, 0);
    reqQ.push_back(32'h3100);
    instQ.push_back(32'h3100);
    waitDrain(30);

    // branch in the same cycle as the response
    lat = 1;
    grant(1);
    reqQ.push_back(32'h3104);
    tick();
    takeBranch = 1; braTarget = 32'h3180;
    #1;
    check("sameCycValid", instValid, 0);
    check("sameCycReq", imemReq, 0);
    tick();
    takeBranch = 0;
    #1;
    check("sameCycTarget", imemAddr, 32'h3180);
    grant(1);
    reqQ.push_back(32'h3180);
    instQ.push_back(32'h3180);
    waitDrain(20);

    // jump beats branch, target bits [1:0] cleared, buffered word flushed
    stall = 1;
    grant(1);
    reqQ.push_back(32'h3184);
    tick();
    tick();
    #1;
    check("heldValid", instValid, 1);
    check("heldPc", instPc, 32'h3184);
    jumpEnable = 1; jumpTarget = 32'h3203;
    takeBranch = 1; braTarget = 32'h3100;
    #1;
    check("redirHidesInst", instValid, 0);
    check("redirNoReq", imemReq, 0);
    tick();
    jumpEnable = 0; takeBranch = 0; stall = 0;
    #1;
    check("flushedBuf", instValid, 0);
    check("jumpTarget", imemAddr, 32'h3200);
    grant(1);
    reqQ.push_back(32'h3200);
    instQ.push_back(32'h3200);
    waitDrain(20);

    // reset while in DROP, stale response lands after reset
    lat = 4;
    grant(1);
    reqQ.push_back(32'h3204);
    tick();
    takeBranch = 1; braTarget = 32'h3300;
    tick();
    takeBranch = 0;
    rst = 1;
    #1;
    check("rstMidReq", imemReq, 0);
    tick();
    rst = 0;
    #1;
    check("postRstAddr", imemAddr, 32'h3000);
    check("postRstReq", imemReq, 1);
    tick();
    tick();
    #1;
    check("staleIgnored", instValid, 0);
    check("restartAddr", imemAddr, 32'h3000);
    grant(1);
    reqQ.push_back(32'h3000);
    instQ.push_back(32'h3000);
    waitDrain(20);
    check("reqQEmpty", reqQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
